bist_pattern_compactor: RTL and testbench

- Self-test wrapper stage for small gate-level CUTs such as the full-adder netlist built from the library cells.
- Drives the CUT inputs from an LFSR pattern source (upstream of the CUT).
- Compacts the CUT responses into a MISR signature (downstream of the CUT).
- Compares the final signature against a golden value and reports pass/fail on a start/done handshake.

---
 rtl/bist_pattern_compactor_if.sv | 36 +++
 rtl/bist_pattern_compactor.sv | 111 +++++++++++
 tb/tb_bist_pattern_compactor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bist_pattern_compactor_if.sv
// BIST wrapper bus: start/busy/done/pass handshake, CUT pattern/response, signature.
// master = controller/CUT side, slave = bist_pattern_compactor; abort only with BIST_ABORT_EN.
interface bist_pattern_compactor_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter int SIG_W = 8
);
  logic             start;
  logic [IN_W-1:0]  cut_in;
  logic [OUT_W-1:0] cut_resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
`ifdef BIST_ABORT_EN
  logic             abort;

  modport master (
    output start, cut_resp, abort,
    input  cut_in, busy, done, pass, signature
  );
  modport slave (
    input  start, cut_resp, abort,
    output cut_in, busy, done, pass, signature
  );
`else
  modport master (
    output start, cut_resp,
    input  cut_in, busy, done, pass, signature
  );
  modport slave (
    input  start, cut_resp,
    output cut_in, busy, done, pass, signature
  );
`endif
endinterface

// File: rtl/bist_pattern_compactor.sv
// BIST stage: LFSR patterns -> CUT -> MISR signature, compared to GOLDEN at end of run.
// Ports: clk, rst_n (async low), bus (slave: start, cut_in, cut_resp, busy, done,
// pass, signature). Optional BIST_ABORT_EN adds bus.abort to cancel a run.
module bist_pattern_compactor #(
  parameter int              IN_W      = 3,
  parameter int              OUT_W     = 2,
  parameter int              LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
  parameter int              SIG_W     = 8,
  parameter logic [SIG_W-1:0] MISR_POLY = 8'h1D,
  parameter int              NUM_PAT   = 16,
  parameter logic [SIG_W-1:0] GOLDEN    = 8'h00
) (
  input logic clk,
  input logic rst_n,
  bist_pattern_compactor_if.slave bus
);
  localparam int CW = $clog2(NUM_PAT + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [SIG_W-1:0]  misr_q, misr_d, misr_abs;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IN_W-1:0]   cut_q, cut_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  assign lfsr_adv = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_POLY)};
  assign misr_abs = {misr_q[SIG_W-2:0], 1'b0}
                  ^ (misr_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ SIG_W'(bus.cut_resp);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    cut_d   = cut_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          cut_d   = LFSR_SEED[IN_W-1:0];
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
`ifdef BIST_ABORT_EN
        if (bus.abort) begin
          // partial signature is kept visible
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else
`endif
        begin
          misr_d = misr_abs;
          lfsr_d = lfsr_adv;
          cut_d  = lfsr_adv[IN_W-1:0];
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (misr_abs == GOLDEN);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      cut_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      cut_q   <= cut_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.cut_in    = cut_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;
endmodule

// File: tb/tb_bist_pattern_compactor.sv
// Directed bench for bist_pattern_compactor with full-adder CUT models.
// Three DUTs: NUM_PAT=1, NUM_PAT=2, NUM_PAT=16 (optional sum stuck-at-0).
module tb_bist_pattern_compactor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bist_pattern_compactor_if #(.IN_W(3), .OUT_W(2), .SIG_W(8)) b1 ();
  bist_pattern_compactor_if #(.IN_W(3), .OUT_W(2), .SIG_W(8)) b2 ();
  bist_pattern_compactor_if #(.IN_W(3), .OUT_W(2), .SIG_W(8)) b16 ();

  bist_pattern_compactor #(.NUM_PAT(1), .GOLDEN(8'h01)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  bist_pattern_compactor #(.NUM_PAT(2), .GOLDEN(8'h04)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );
  bist_pattern_compactor #(.NUM_PAT(16), .GOLDEN(8'h7A)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );

  // full adder {ci,b,a} -> {co,s}; f forces s to 0
  function automatic logic [1:0] fa(input logic [2:0] x, input logic f);
    logic co;
    co = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    return {co, (^x) & ~f};
  endfunction

  assign b1.cut_resp  = fa(b1.cut_in, 1'b0);
  assign b2.cut_resp  = fa(b2.cut_in, 1'b0);
  assign b16.cut_resp = fa(b16.cut_in, fault);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start held for `hold` edges; returns edges to done, busy samples, done after edge 1
  task automatic run16(input int hold, output int edges, output int busy_n,
                       output logic d1);
    edges  = 0;
    busy_n = 0;
    d1     = 1'b0;
    b16.start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      edges++;
      if (edges == 1) d1 = b16.done;
      if (edges >= hold) b16.start = 1'b0;
      if (b16.busy) busy_n++;
      if (b16.done) break;
    end
    b16.start = 1'b0;
    check("done_seen", b16.done, 1);
  endtask

  int e, bn;
  logic d1;

  initial begin
    b1.start = 1'b0;
    b2.start = 1'b0;
    b16.start = 1'b0;
`ifdef BIST_ABORT_EN
    b1.abort = 1'b0;
    b2.abort = 1'b0;
    b16.abort = 1'b0;
`endif
    repeat (2) tick();
    check("rst_busy", b16.busy, 0);
    check("rst_done", b16.done, 0);
    check("rst_pass", b16.pass, 0);
    check("rst_sig", b16.signature, 0);
    check("rst_cut", b16.cut_in, 0);
    rst_n = 1'b1;
    tick();

    // NUM_PAT=1
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("p1_cut", b1.cut_in, 3'b001);
    check("p1_busy", b1.busy, 1);
    check("p1_done0", b1.done, 0);
    tick();
    check("p1_done", b1.done, 1);
    check("p1_busy_end", b1.busy, 0);
    check("p1_sig", b1.signature, 8'h01);
    check("p1_pass", b1.pass, 1);
    tick();
    check("p1_sig_hold", b1.signature, 8'h01);
    check("p1_done_hold", b1.done, 1);

    // NUM_PAT=2, GOLDEN mismatch
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    check("p2_cut0", b2.cut_in, 3'b001);
    check("p2_busy0", b2.busy, 1);
    tick();
    check("p2_cut1", b2.cut_in, 3'b010);
    check("p2_busy1", b2.busy, 1);
    check("p2_done1", b2.done, 0);
    tick();
    check("p2_done", b2.done, 1);
    check("p2_busy_end", b2.busy, 0);
    check("p2_sig", b2.signature, 8'h03);
    check("p2_pass", b2.pass, 0);

    // NUM_PAT=16 clean
    run16(1, e, bn, d1);
    check("c_edges", e, 17);
    check("c_busy_n", bn, 16);
    check("c_sig", b16.signature, 8'h7A);
    check("c_pass", b16.pass, 1);

    // sum stuck-at-0
    fault = 1'b1;
    run16(1, e, bn, d1);
    check("f_d1", d1, 0);
    check("f_sig", b16.signature, 8'hA4);
    check("f_pass", b16.pass, 0);
    fault = 1'b0;

    // reset mid-run after 5 absorbs
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    repeat (5) tick();
    check("r_sig5", b16.signature, 8'h1D);
    check("r_busy5", b16.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_busy", b16.busy, 0);
    check("r_done", b16.done, 0);
    check("r_pass", b16.pass, 0);
    check("r_sig", b16.signature, 0);
    check("r_cut", b16.cut_in, 0);
    #2 rst_n = 1'b1;
    run16(1, e, bn, d1);
    check("r_edges", e, 17);
    check("r_sig_clean", b16.signature, 8'h7A);
    check("r_pass_clean", b16.pass, 1);

    // start held 4 cycles, then restart from DONE
    run16(4, e, bn, d1);
    check("h_edges", e, 17);
    check("h_busy_n", bn, 16);
    check("h_sig", b16.signature, 8'h7A);
    run16(1, e, bn, d1);
    check("h2_d1", d1, 0);
    check("h2_edges", e, 17);
    check("h2_sig", b16.signature, 8'h7A);
    check("h2_pass", b16.pass, 1);

`ifdef BIST_ABORT_EN
    // abort after 3 absorbs
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    repeat (3) tick();
    b16.abort = 1'b1;
    tick();
    b16.abort = 1'b0;
    check("a_busy", b16.busy, 0);
    check("a_done", b16.done, 0);
    check("a_pass", b16.pass, 0);
    check("a_sig", b16.signature, 8'h07);
    repeat (3) tick();
    check("a_sig_hold", b16.signature, 8'h07);
    check("a_idle", b16.busy, 0);
    check("a_done_hold", b16.done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
